// File: rtl/tc_sram_initiator_pkg.sv
// Shared types and constants for the SRAM initiator and its response FIFO.
//   state_e        : initiator FSM states
//   RspFifoDepth   : read-response FIFO depth
//   RspCntWidth    : width of the FIFO occupancy count
package tc_sram_initiator_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int unsigned RspFifoDepth = 32'd3;
    localparam int unsigned RspCntWidth  = $clog2(RspFifoDepth + 32'd1);

endpackage

// File: rtl/tc_sram_initiator_rsp_fifo.sv
// Read-response FIFO: small circular buffer with an occupancy count.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   push_i, wdata_i     : enqueue one data word
//   pop_i               : dequeue when data is valid
//   rdata_o, valid_o    : head of queue (zero when empty)
//   count_o             : number of entries held
module tc_sram_initiator_rsp_fifo
    import tc_sram_initiator_pkg::*;
#(
    parameter int unsigned DataWidth = 32'd128
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic                   pop_i,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   valid_o,
    output logic [RspCntWidth-1:0] count_o
);

    localparam int unsigned PtrWidth = $clog2(RspFifoDepth);

    logic [DataWidth-1:0]   mem_q [RspFifoDepth];
    logic [PtrWidth-1:0]    wr_ptr;
    logic [PtrWidth-1:0]    rd_ptr;
    logic [RspCntWidth-1:0] count_q;
    logic                   do_pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RspFifoDepth - 32'd1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign rdata_o = valid_o ? mem_q[rd_ptr] : '0;

    // Storage needs no reset; emptiness is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr] <= wdata_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + RspCntWidth'(1);
                2'b01:   count_q <= count_q - RspCntWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tc_sram_initiator.sv
// Two-port SRAM initiator: port 0 serves an upstream read/write request
// channel with an in-order read-response queue; port 1 zero-fills the
// whole memory on request.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   req_*                         : upstream request handshake and payload
//   rsp_*                         : read-response channel
//   mem_*                         : two-port SRAM master side (index = port)
//   clear_i, busy_o, clear_done_o : zero-fill start, in-progress, done pulse
module tc_sram_initiator
    import tc_sram_initiator_pkg::*;
#(
    parameter  int unsigned NumWords  = 32'd1024,
    parameter  int unsigned DataWidth = 32'd128,
    parameter  int unsigned ByteWidth = 32'd8,
    localparam int unsigned AddrWidth = (NumWords > 32'd1) ? $clog2(NumWords) : 32'd1,
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 32'd1) / ByteWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [AddrWidth-1:0]      req_addr_i,
    input  logic [DataWidth-1:0]      req_wdata_i,
    input  logic [BeWidth-1:0]        req_be_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DataWidth-1:0]      rsp_rdata_o,
    output logic [1:0]                mem_req_o,
    output logic [1:0]                mem_we_o,
    output logic [1:0][AddrWidth-1:0] mem_addr_o,
    output logic [1:0][DataWidth-1:0] mem_wdata_o,
    output logic [1:0][BeWidth-1:0]   mem_be_o,
    input  logic [1:0][DataWidth-1:0] mem_rdata_i,
    input  logic                      clear_i,
    output logic                      busy_o,
    output logic                      clear_done_o
);

    localparam int unsigned SlotWidth = RspCntWidth + 32'd1;

    state_e                 state;
    logic [AddrWidth-1:0]   clr_addr;
    logic                   rd_inflight;
    logic [RspCntWidth-1:0] fifo_count;
    logic                   req_hs;
    logic                   in_clear;
    logic                   unused_rdata1;

    // Port 1 only writes; its read data is intentionally ignored.
    assign unused_rdata1 = ^mem_rdata_i[1];

    assign in_clear = (state == CLEAR);

    // Reserve a FIFO slot for every read still in flight.
    assign req_ready_o = !rst_i && (state == IDLE) && !clear_i &&
                         ((SlotWidth'(fifo_count) + SlotWidth'(rd_inflight)) <
                          SlotWidth'(RspFifoDepth));
    assign req_hs = req_valid_i && req_ready_o;

    // Port 0 forwards the accepted request; port 1 is the zero-fill engine.
    always_comb begin
        mem_req_o      = {in_clear, req_hs};
        mem_we_o       = {in_clear, req_hs && req_we_i};
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        mem_be_o       = '0;
        if (req_hs) begin
            mem_addr_o[0]  = req_addr_i;
            mem_wdata_o[0] = req_wdata_i;
            mem_be_o[0]    = req_be_i;
        end
        if (in_clear) begin
            mem_addr_o[1] = clr_addr;
            mem_be_o[1]   = '1;
        end
    end

    // FSM, clear address counter and read-in-flight tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            clr_addr     <= '0;
            busy_o       <= 1'b0;
            clear_done_o <= 1'b0;
            rd_inflight  <= 1'b0;
        end else begin
            clear_done_o <= 1'b0;
            rd_inflight  <= req_hs && !req_we_i;
            case (state)
                IDLE: begin
                    if (clear_i) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        busy_o   <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_addr == AddrWidth'(NumWords - 32'd1)) begin
                        state        <= IDLE;
                        clr_addr     <= '0;
                        busy_o       <= 1'b0;
                        clear_done_o <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + AddrWidth'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data arrives one cycle after the port-0 read and is queued.
    tc_sram_initiator_rsp_fifo #(
        .DataWidth (DataWidth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rd_inflight),
        .wdata_i (mem_rdata_i[0]),
        .pop_i   (rsp_ready_i),
        .rdata_o (rsp_rdata_o),
        .valid_o (rsp_valid_o),
        .count_o (fifo_count)
    );

endmodule
